// File: rtl/am2940_seq_ctrl.sv
// AM2940 instruction decoder and transfer sequencer: owns CR/AR/AC/WR/WC,
// steps the counters while running and flags end-of-transfer per mode.
module am2940_seq_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    instr,
  input  logic          instr_vld,
  input  logic [DW-1:0] din,
  input  logic          cnt_en,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          done,
  output logic          aco,
  output logic          running,
  output logic [1:0]    state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] I_WRCR = 3'd0;
  localparam logic [2:0] I_RDCR = 3'd1;
  localparam logic [2:0] I_RDWC = 3'd2;
  localparam logic [2:0] I_RDAC = 3'd3;
  localparam logic [2:0] I_REIN = 3'd4;
  localparam logic [2:0] I_LDAD = 3'd5;
  localparam logic [2:0] I_LDWC = 3'd6;
  localparam logic [2:0] I_ENCT = 3'd7;

  logic [2:0]    cr_q, cr_d;
  logic [DW-1:0] ar_q, ar_d, ac_q, ac_d, wr_q, wr_d, wc_q, wc_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0]    state_q, state_d;
  logic          dout_vld_q, dout_vld_d, done_q, done_d, aco_q, aco_d;

  logic [1:0]    mode;
  logic          wr_cls, ac_wrap, step_hit, cur_hit, reload;
  logic [DW-1:0] ac_step, wc_step;

  // Termination test for the programmed mode on a given AC/WC pair.
  function automatic logic hit(input logic [1:0] m, input logic [DW-1:0] ac,
                               input logic [DW-1:0] wc, input logic [DW-1:0] wr);
    case (m)
      2'b01:   hit = (wc == wr);
      2'b11:   hit = (ac == wr);
      default: hit = (wc == '0);
    endcase
  endfunction

  assign mode   = cr_q[1:0];
  assign wr_cls = instr_vld && (instr == I_WRCR || instr == I_REIN ||
                                instr == I_LDAD || instr == I_LDWC);

  always_comb begin
    ac_step = cr_q[2] ? ac_q - 1'b1 : ac_q + 1'b1;
    ac_wrap = cr_q[2] ? (ac_q == '0) : (ac_q == '1);
    case (mode)
      2'b01:   wc_step = wc_q + 1'b1;
      2'b11:   wc_step = wc_q;
      default: wc_step = wc_q - 1'b1;
    endcase
    step_hit = hit(mode, ac_step, wc_step, wr_q);
    cur_hit  = hit(mode, ac_q, wc_q, wr_q);
  end

  always_comb begin
    cr_d       = cr_q;
    ar_d       = ar_q;
    ac_d       = ac_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    state_d    = state_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    aco_d      = 1'b0;
    reload     = 1'b0;
    if (instr_vld) begin
      case (instr)
        I_WRCR: cr_d = din[2:0];
        I_RDCR: begin dout_d = {{(DW-3){1'b1}}, cr_q}; dout_vld_d = 1'b1; end
        I_RDWC: begin dout_d = wc_q; dout_vld_d = 1'b1; end
        I_RDAC: begin dout_d = ac_q; dout_vld_d = 1'b1; end
        I_REIN: begin ac_d = ar_q; wc_d = (mode == 2'b01) ? '0 : wr_q; end
        I_LDAD: begin ar_d = din; ac_d = din; end
        I_LDWC: begin wr_d = din; wc_d = (mode == 2'b01) ? '0 : din; end
        I_ENCT: if (state_q == S_IDLE) state_d = cur_hit ? S_DONE : S_RUN;
        default: ;
      endcase
    end
    if (wr_cls) begin
      state_d = S_IDLE;
    end else if (state_q == S_RUN && cnt_en) begin
      ac_d  = ac_step;
      wc_d  = wc_step;
      aco_d = ac_wrap;
      if (step_hit) begin
        // Auto-reload only with a non-zero word count, else it would spin.
        if (mode == 2'b10 && wr_q != '0) begin
          ac_d   = ar_q;
          wc_d   = wr_q;
          reload = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
    end
    done_d = (state_d == S_DONE) || reload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q       <= '0;
      ar_q       <= '0;
      ac_q       <= '0;
      wr_q       <= '0;
      wc_q       <= '0;
      state_q    <= S_IDLE;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
      aco_q      <= 1'b0;
    end else begin
      cr_q       <= cr_d;
      ar_q       <= ar_d;
      ac_q       <= ac_d;
      wr_q       <= wr_d;
      wc_q       <= wc_d;
      state_q    <= state_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      done_q     <= done_d;
      aco_q      <= aco_d;
    end
  end

  assign addr     = ac_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign done     = done_q;
  assign aco      = aco_q;
  assign running  = (state_q == S_RUN);
  assign state_o  = state_q;

endmodule

// File: tb/tb_am2940_seq_ctrl.sv
// Directed plus randomized bench for am2940_seq_ctrl against a behavioural
// model of the register/counter rules kept as plain integers.
`timescale 1ns/100ps
module tb_am2940_seq_ctrl;

  localparam int WRCR = 0, RDCR = 1, RDWC = 2, RDAC = 3;
  localparam int REIN = 4, LDAD = 5, LDWC = 6, ENCT = 7;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] instr = '0;
  logic       instr_vld = 1'b0;
  logic [7:0] din = '0;
  logic       cnt_en = 1'b0;
  logic [7:0] addr, dout;
  logic       dout_vld, done, aco, running;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int m_cr, m_ar, m_ac, m_wr, m_wc, m_st;
  int e_dout;
  bit e_vld, e_done, e_aco;

  am2940_seq_ctrl #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_vld(instr_vld),
    .din(din), .cnt_en(cnt_en), .addr(addr), .dout(dout),
    .dout_vld(dout_vld), .done(done), .aco(aco), .running(running),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cr = 0; m_ar = 0; m_ac = 0; m_wr = 0; m_wc = 0; m_st = M_IDLE;
    e_dout = 0; e_vld = 0; e_done = 0; e_aco = 0;
  endtask

  function automatic bit m_hit(input int mode, input int ac, input int wc);
    if (mode == 1) return wc == m_wr;
    if (mode == 3) return ac == m_wr;
    return wc == 0;
  endfunction

  task automatic model_edge(input bit v, input int i, input int d, input bit ce);
    int  mode, st0, ac_n, wc_n;
    bit  down, wr_cls, pulse;
    mode = m_cr % 4;
    down = (m_cr >= 4);
    st0  = m_st;
    wr_cls = v && (i == WRCR || i == REIN || i == LDAD || i == LDWC);
    e_vld = 0; e_aco = 0; pulse = 0;
    if (v) begin
      case (i)
        WRCR: m_cr = d % 8;
        RDCR: begin e_dout = 248 + m_cr; e_vld = 1; end
        RDWC: begin e_dout = m_wc; e_vld = 1; end
        RDAC: begin e_dout = m_ac; e_vld = 1; end
        REIN: begin m_ac = m_ar; m_wc = (mode == 1) ? 0 : m_wr; end
        LDAD: begin m_ar = d; m_ac = d; end
        LDWC: begin m_wr = d; m_wc = (mode == 1) ? 0 : d; end
        default: if (m_st == M_IDLE) m_st = m_hit(mode, m_ac, m_wc) ? M_DONE : M_RUN;
      endcase
    end
    if (wr_cls) m_st = M_IDLE;
    else if (st0 == M_RUN && ce) begin
      ac_n  = down ? (m_ac + 255) % 256 : (m_ac + 1) % 256;
      e_aco = down ? (m_ac == 0) : (m_ac == 255);
      if (mode == 0 || mode == 2) wc_n = (m_wc + 255) % 256;
      else if (mode == 1) wc_n = (m_wc + 1) % 256;
      else wc_n = m_wc;
      m_ac = ac_n; m_wc = wc_n;
      if (m_hit(mode, ac_n, wc_n)) begin
        if (mode == 2 && m_wr != 0) begin
          m_ac = m_ar; m_wc = m_wr; pulse = 1;
        end else m_st = M_DONE;
      end
    end
    e_done = (m_st == M_DONE) || pulse;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_addr"}, addr, 8'(m_ac));
    chk({tag, "_dout"}, dout, 8'(e_dout));
    chk({tag, "_dvld"}, {7'd0, dout_vld}, {7'd0, e_vld});
    chk({tag, "_done"}, {7'd0, done}, {7'd0, e_done});
    chk({tag, "_aco"}, {7'd0, aco}, {7'd0, e_aco});
    chk({tag, "_run"}, {7'd0, running}, {7'd0, m_st == M_RUN});
  endtask

  task automatic cyc(input string tag, input bit v, input int i, input int d, input bit ce);
    @(negedge clk);
    instr_vld = v; instr = 3'(i); din = 8'(d); cnt_en = ce;
    @(posedge clk);
    model_edge(v, i, d, ce);
    #1;
    check_all(tag);
  endtask

  task automatic op(input string tag, input int i, input int d);
    cyc(tag, 1'b1, i, d, 1'b0);
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, 1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // mode 00 count-down transfer
    op("t1", WRCR, 0); op("t1", LDAD, 8'h10); op("t1", LDWC, 8'h03);
    cyc("t1_enct", 1'b1, ENCT, 0, 1'b1);
    steps("t1_step", 3);
    chk("t1_final_addr", addr, 8'h13);
    chk("t1_final_done", {7'd0, done}, 8'd1);
    steps("t1_hold", 2);
    chk("t1_hold_addr", addr, 8'h13);

    // address down with wrap
    op("t2", WRCR, 3'b100); op("t2", LDAD, 8'h01); op("t2", LDWC, 8'h05);
    op("t2", ENCT, 0);
    steps("t2_step", 2);
    chk("t2_aco", {7'd0, aco}, 8'd1);
    chk("t2_addr_ff", addr, 8'hFF);
    steps("t2_step", 1);
    chk("t2_addr_fe", addr, 8'hFE);
    cyc("t2_rdwc", 1'b1, RDWC, 0, 1'b0);
    chk("t2_rdwc_dout", dout, 8'h02);
    cyc("t2_after", 1'b0, 0, 0, 1'b0);

    // auto-reload
    op("t3", WRCR, 3'b010); op("t3", LDAD, 8'h40); op("t3", LDWC, 8'h02);
    op("t3", ENCT, 0);
    steps("t3_step", 5);
    steps("t3_last", 1);
    chk("t3_addr", addr, 8'h40);
    chk("t3_pulse", {7'd0, done}, 8'd1);
    chk("t3_running", {7'd0, running}, 8'd1);

    // address-compare and immediate done
    op("t4", WRCR, 3'b011); op("t4", LDWC, 8'h20); op("t4", LDAD, 8'h1E);
    op("t4", ENCT, 0);
    steps("t4_step", 2);
    chk("t4_done_addr", addr, 8'h20);
    op("t4b", WRCR, 3'b001); op("t4b", LDWC, 8'h00);
    op("t4b_enct", ENCT, 0);
    chk("t4b_done", {7'd0, done}, 8'd1);
    steps("t4b_nostep", 1);
    chk("t4b_addr", addr, 8'h20);

    // write-class priority and read concurrent with step
    op("t5", WRCR, 0); op("t5", LDAD, 0); op("t5", LDWC, 8'h10);
    op("t5", ENCT, 0);
    steps("t5_step", 2);
    cyc("t5_ldad", 1'b1, LDAD, 8'h80, 1'b1);
    chk("t5_ldad_addr", addr, 8'h80);
    op("t5", ENCT, 0);
    cyc("t5_rdac", 1'b1, RDAC, 0, 1'b1);
    chk("t5_rdac_dout", dout, 8'h80);
    chk("t5_rdac_addr", addr, 8'h81);

    // asynchronous reset in the middle of a run
    op("t6", WRCR, 0); op("t6", LDAD, 8'h05); op("t6", LDWC, 8'h09);
    op("t6", ENCT, 0);
    steps("t6_step", 1);
    #2.5;
    rst_n = 1'b0;
    #0.5;
    model_reset();
    check_all("t6_async");
    #0.5;
    rst_n = 1'b1;
    op("t6_rdcr", RDCR, 0);
    chk("t6_rdcr_val", dout, 8'hF8);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit v;
      int i, d;
      v = ($urandom_range(0, 9) < 4);
      i = $urandom_range(0, 7);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      if (i == 0 && v) d = $urandom_range(0, 7);
      cyc("rnd", v, i, d, ($urandom_range(0, 9) < 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
